// File: rtl/fetch_sprime_if.sv
// fetch_sprime_if
//   Bundles the start/done handshake, the SRAM read port and the
//   embedded DP-RAM write port used by fetch_sprime.
//   Ports:
//     FS_start          request one block fetch
//     FS_done           one-cycle pulse after the last DP-RAM word is written
//     SRAM_address      18-bit SRAM read address
//     SRAM_we_n         SRAM write enable, active low (always 1 here)
//     SRAM_read_data    16-bit SRAM read data, two cycles behind the address
//     dp_write_address  DP-RAM word address (0..31 used)
//     dp_write_data     {even sample, odd sample}
//     dp_write_enable   DP-RAM write strobe
//   master: the fetch engine; slave: the SRAM / DP-RAM / controller side.
interface fetch_sprime_if;
  logic        FS_start;
  logic        FS_done;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic [6:0]  dp_write_address;
  logic [31:0] dp_write_data;
  logic        dp_write_enable;

  modport master (
    input  FS_start,
    output FS_done,
    output SRAM_address,
    output SRAM_we_n,
    input  SRAM_read_data,
    output dp_write_address,
    output dp_write_data,
    output dp_write_enable
  );

  modport slave (
    output FS_start,
    input  FS_done,
    input  SRAM_address,
    input  SRAM_we_n,
    output SRAM_read_data,
    input  dp_write_address,
    input  dp_write_data,
    input  dp_write_enable
  );
endinterface

// File: rtl/fetch_sprime.sv
// fetch_sprime
//   Reads one 8x8 block of S' coefficients from SRAM and packs them two
//   per word into the embedded DP-RAM (32 words). Successive start pulses
//   walk the Y, U and V regions in block raster order.
//   Ports:
//     CLOCK_50_I  50 MHz clock, rising edge
//     Reset       synchronous, active-high
//     fs          fetch_sprime_if.master (handshake, SRAM read, DP-RAM write)
module fetch_sprime (
  input  logic           CLOCK_50_I,
  input  logic           Reset,
  fetch_sprime_if.master fs
);

  localparam logic [2:0] S_FS_IDLE = 3'd0;
  localparam logic [2:0] S_FS_LI_1 = 3'd1;
  localparam logic [2:0] S_FS_LI_2 = 3'd2;
  localparam logic [2:0] S_FS_CC   = 3'd3;
  localparam logic [2:0] S_FS_LO_1 = 3'd4;
  localparam logic [2:0] S_FS_LO_2 = 3'd5;

  localparam logic [17:0] Y_BASE = 18'd76800;
  localparam logic [17:0] U_BASE = 18'd153600;
  localparam logic [17:0] V_BASE = 18'd192000;

  localparam logic [1:0] PLANE_Y = 2'd0;
  localparam logic [1:0] PLANE_U = 2'd1;
  localparam logic [1:0] PLANE_V = 2'd2;

  logic [2:0]  state;
  logic [5:0]  sc;
  logic [5:0]  cb;
  logic [4:0]  rb;
  logic [1:0]  plane;
  logic [17:0] sram_address;

  logic        rd1_valid;
  logic [5:0]  rd1_idx;
  logic        rd2_valid;
  logic        rd2_even;
  logic [15:0] hold;
  logic        dp_we;
  logic [6:0]  dp_addr;
  logic        done;

  logic        issuing;
  logic [5:0]  sc_next;
  logic [7:0]  row;
  logic [8:0]  col;
  logic [17:0] row_ext;
  logic [17:0] row_offset;
  logic [17:0] base;
  logic [17:0] next_address;
  logic [5:0]  cb_last;

  // Reads go out in the two fill states and the steady state, one per cycle.
  assign issuing = (state == S_FS_LI_1) || (state == S_FS_LI_2) || (state == S_FS_CC);

  // Address of the sample that will be on the bus next cycle. In IDLE this is
  // sample 0 so the first address is already driven in the cycle after start.
  always_comb begin
    sc_next    = issuing ? sc + 6'd1 : 6'd0;
    row        = {rb, 3'b000} + {5'b00000, sc_next[5:3]};
    col        = {cb, 3'b000} + {6'b000000, sc_next[2:0]};
    row_ext    = {10'd0, row};
    base       = Y_BASE;
    row_offset = (row_ext << 8) + (row_ext << 6);
    case (plane)
      PLANE_U: begin
        base       = U_BASE;
        row_offset = (row_ext << 7) + (row_ext << 5);
      end
      PLANE_V: begin
        base       = V_BASE;
        row_offset = (row_ext << 7) + (row_ext << 5);
      end
      default: ;
    endcase
    next_address = base + row_offset + {9'd0, col};
    cb_last      = (plane == PLANE_Y) ? 6'd39 : 6'd19;
  end

  // Control: state sequencing, sample counter, address register and the
  // block/plane walk, which steps once the final read of a block is issued.
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state        <= S_FS_IDLE;
      sc           <= 6'd0;
      cb           <= 6'd0;
      rb           <= 5'd0;
      plane        <= PLANE_Y;
      sram_address <= 18'd0;
    end else begin
      case (state)
        S_FS_IDLE: begin
          if (fs.FS_start) begin
            state        <= S_FS_LI_1;
            sc           <= 6'd0;
            sram_address <= next_address;
          end
        end
        S_FS_LI_1: state <= S_FS_LI_2;
        S_FS_LI_2: state <= S_FS_CC;
        S_FS_CC: begin
          if (sc == 6'd63) state <= S_FS_LO_1;
        end
        S_FS_LO_1: state <= S_FS_LO_2;
        S_FS_LO_2: state <= S_FS_IDLE;
        default:   state <= S_FS_IDLE;
      endcase

      if (issuing) begin
        if (sc != 6'd63) begin
          sc           <= sc + 6'd1;
          sram_address <= next_address;
        end else begin
          sc <= 6'd0;
          if (cb == cb_last) begin
            cb <= 6'd0;
            if (rb == 5'd29) begin
              rb    <= 5'd0;
              plane <= (plane == PLANE_V) ? PLANE_Y : plane + 2'd1;
            end else begin
              rb <= rb + 5'd1;
            end
          end else begin
            cb <= cb + 6'd1;
          end
        end
      end
    end
  end

  // Read-data pipeline: tags follow each address for the two-cycle SRAM
  // latency. The write strobe is raised one cycle early so it lines up with
  // the odd sample's data arriving on SRAM_read_data.
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      rd1_valid <= 1'b0;
      rd1_idx   <= 6'd0;
      rd2_valid <= 1'b0;
      rd2_even  <= 1'b0;
      hold      <= 16'd0;
      dp_we     <= 1'b0;
      dp_addr   <= 7'd0;
      done      <= 1'b0;
    end else begin
      rd1_valid <= issuing;
      rd1_idx   <= sc;
      rd2_valid <= rd1_valid;
      rd2_even  <= ~rd1_idx[0];
      if (rd2_valid && rd2_even) hold <= fs.SRAM_read_data;
      dp_we <= rd1_valid && rd1_idx[0];
      if (rd1_valid && rd1_idx[0]) dp_addr <= {2'b00, rd1_idx[5:1]};
      done <= dp_we && (dp_addr == 7'd31);
    end
  end

  // The odd sample is taken straight from the SRAM bus in its write cycle;
  // the data bus reads zero whenever no write is in progress.
  assign fs.dp_write_data    = dp_we ? {hold, fs.SRAM_read_data} : 32'd0;
  assign fs.dp_write_enable  = dp_we;
  assign fs.dp_write_address = dp_addr;
  assign fs.SRAM_address     = sram_address;
  assign fs.SRAM_we_n        = 1'b1;
  assign fs.FS_done          = done;

endmodule

// File: tb/tb_fetch_sprime.sv
// tb_fetch_sprime
//   Self-checking bench for fetch_sprime. An SRAM model with two cycles of
//   read latency and a DP-RAM capture array surround the DUT; expected
//   addresses, strobes and packed words come from a block-index model.
module tb_fetch_sprime;

  logic clk;
  logic rst;

  fetch_sprime_if bus ();

  fetch_sprime dut (
    .CLOCK_50_I(clk),
    .Reset     (rst),
    .fs        (bus)
  );

  logic [15:0] sram [0:262143];
  logic [31:0] dpmem [0:31];
  logic [15:0] rd_pipe;

  int check_count;
  int pass_count;
  int m_block;
  int obs_addr [0:63];
  int done_count;
  int we_count;
  int done_first;
  int done_second;

  logic [1:0] f_plane;
  logic [4:0] f_rb;
  logic [5:0] f_cb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: address in cycle i, data on the bus in cycle i+2.
  always @(posedge clk) begin
    rd_pipe            <= sram[bus.SRAM_address];
    bus.SRAM_read_data <= rd_pipe;
  end

  // DP-RAM model captures on the edge that ends a write cycle.
  always @(posedge clk) begin
    if (bus.dp_write_enable) dpmem[bus.dp_write_address[4:0]] <= bus.dp_write_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    else
      pass_count++;
  endtask

  // Block index 0..2399 covers Y (1200 blocks), then U and V (600 each).
  function automatic int exp_addr(input int b, input int i);
    int base, width, cols, local_b, r, c;
    if (b < 1200) begin
      base = 76800; width = 320; cols = 40; local_b = b;
    end else if (b < 1800) begin
      base = 153600; width = 160; cols = 20; local_b = b - 1200;
    end else begin
      base = 192000; width = 160; cols = 20; local_b = b - 1800;
    end
    r = local_b / cols;
    c = local_b % cols;
    return base + width * (8 * r + i / 8) + 8 * c + i % 8;
  endfunction

  function automatic int block_index(input int p, input int r, input int c);
    if (p == 0) return r * 40 + c;
    if (p == 1) return 1200 + r * 20 + c;
    return 1800 + r * 20 + c;
  endfunction

  // Place the DUT's block walk at an arbitrary position while it is idle.
  task automatic forceBlock(input int p, input int r, input int c);
    f_plane = p[1:0];
    f_rb    = r[4:0];
    f_cb    = c[5:0];
    @(negedge clk);
    force dut.plane = f_plane;
    force dut.rb    = f_rb;
    force dut.cb    = f_cb;
    @(posedge clk);
    #1;
    release dut.plane;
    release dut.rb;
    release dut.cb;
    m_block = block_index(p, r, c);
  endtask

  // One start pulse; checks every cycle 0..66 and the 32 packed words.
  task automatic applyStimulus();
    logic [31:0] exp_word;
    for (int w = 0; w < 32; w++) dpmem[w] = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.FS_start = 1'b1;
    @(posedge clk);
    #1;
    bus.FS_start = 1'b0;
    for (int n = 0; n <= 66; n++) begin
      if (n < 64) begin
        obs_addr[n] = int'(bus.SRAM_address);
        checkOutput("sram_addr", {14'd0, bus.SRAM_address}, exp_addr(m_block, n));
      end
      checkOutput("we_n", {31'd0, bus.SRAM_we_n}, 32'd1);
      if (n >= 3 && n <= 65 && (n % 2) == 1) begin
        checkOutput("dp_we", {31'd0, bus.dp_write_enable}, 32'd1);
        checkOutput("dp_addr", {25'd0, bus.dp_write_address}, (n - 3) / 2);
      end else begin
        checkOutput("dp_we", {31'd0, bus.dp_write_enable}, 32'd0);
      end
      checkOutput("fs_done", {31'd0, bus.FS_done}, (n == 66) ? 32'd1 : 32'd0);
      if (n < 66) begin
        @(posedge clk);
        #1;
      end
    end
    for (int w = 0; w < 32; w++) begin
      exp_word = {sram[exp_addr(m_block, 2 * w)], sram[exp_addr(m_block, 2 * w + 1)]};
      checkOutput("dp_word", dpmem[w], exp_word);
    end
    m_block = (m_block + 1) % 2400;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_addr", {14'd0, bus.SRAM_address}, 32'd0);
    checkOutput("rst_we_n", {31'd0, bus.SRAM_we_n}, 32'd1);
    checkOutput("rst_dp_addr", {25'd0, bus.dp_write_address}, 32'd0);
    checkOutput("rst_dp_data", bus.dp_write_data, 32'd0);
    checkOutput("rst_dp_we", {31'd0, bus.dp_write_enable}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.FS_done}, 32'd0);
  endtask

  initial begin
    int p, r, c, gap;
    check_count  = 0;
    pass_count   = 0;
    m_block      = 0;
    rst          = 1'b1;
    bus.FS_start = 1'b0;
    for (int a = 0; a < 262144; a++) sram[a] = 16'($urandom);
    for (int k = 0; k < 2560; k++) sram[76800 + k] = 16'(k);
    sram[76808] = 16'h8001;

    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] Y block (0,0)");
    applyStimulus();
    checkOutput("y00_first", obs_addr[0], 32'd76800);
    checkOutput("y00_c7", obs_addr[7], 32'd76807);
    checkOutput("y00_row1", obs_addr[8], 32'd77120);
    checkOutput("y00_w0", dpmem[0], 32'h0000_0001);
    checkOutput("y00_w31", dpmem[31], {16'd2246, 16'd2247});

    $display("[TB] Y block (0,1)");
    applyStimulus();
    checkOutput("y01_first", obs_addr[0], 32'd76808);
    checkOutput("y01_neg", dpmem[0], {16'h8001, 16'd9});

    $display("[TB] Y to U transition");
    forceBlock(0, 29, 39);
    applyStimulus();
    checkOutput("y_last", obs_addr[63], 32'd153599);
    applyStimulus();
    checkOutput("u_first", obs_addr[0], 32'd153600);
    checkOutput("u_row1", obs_addr[8], 32'd153760);

    $display("[TB] plane wrap");
    forceBlock(2, 29, 19);
    applyStimulus();
    checkOutput("v_last", obs_addr[63], 32'd230399);
    applyStimulus();
    checkOutput("wrap_first", obs_addr[0], 32'd76800);

    $display("[TB] random blocks");
    for (int t = 0; t < 6; t++) begin
      p = $urandom_range(0, 2);
      r = $urandom_range(0, 29);
      c = (p == 0) ? $urandom_range(0, 39) : $urandom_range(0, 19);
      forceBlock(p, r, c);
      gap = $urandom_range(0, 4);
      repeat (gap) @(posedge clk);
      #1;
      applyStimulus();
    end

    $display("[TB] reset mid-fetch");
    @(negedge clk);
    bus.FS_start = 1'b1;
    @(posedge clk);
    #1;
    bus.FS_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetOutputs();
    for (int n = 0; n < 70; n++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_no_we", {31'd0, bus.dp_write_enable}, 32'd0);
      checkOutput("rst_no_done", {31'd0, bus.FS_done}, 32'd0);
    end
    m_block = 0;
    applyStimulus();
    checkOutput("rst_restart", obs_addr[0], 32'd76800);

    $display("[TB] busy start");
    done_count  = 0;
    we_count    = 0;
    done_first  = -1;
    done_second = -1;
    @(negedge clk);
    bus.FS_start = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n <= 133; n++) begin
      if (bus.FS_done) begin
        done_count++;
        if (done_first < 0) done_first = n;
        else if (done_second < 0) done_second = n;
      end
      if (bus.dp_write_enable) we_count++;
      if (n == 133) bus.FS_start = 1'b0;
      else begin
        @(posedge clk);
        #1;
      end
    end
    for (int n = 0; n < 70; n++) begin
      @(posedge clk);
      #1;
      if (bus.FS_done) done_count++;
      if (bus.dp_write_enable) we_count++;
    end
    checkOutput("busy_dones", done_count, 32'd2);
    checkOutput("busy_writes", we_count, 32'd64);
    checkOutput("busy_done1", done_first, 32'd66);
    checkOutput("busy_done2", done_second, 32'd133);
    m_block = (m_block + 2) % 2400;
    applyStimulus();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
